// File: rtl/samples_decimate.sv
// samples_decimate: receive-side symbol decimator.
// Tracks symbol phase with a modulo-RATIO counter that is realigned by sym_sync
// and emits one value per symbol on a one-cycle data_valid strobe.
// Optional build macro SAMPLES_DECIMATE_AVG_EN selects integrate-and-dump
// (average of the RATIO samples of each symbol) instead of point sampling.
module samples_decimate #(
    parameter  int WIDTH = 16,
    parameter  int RATIO = 8,
    parameter  int PHASE = 0,
    localparam int CW    = $clog2(RATIO)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    input  logic             sym_sync,
    input  logic [CW-1:0]    phase_sel,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             locked
);

    typedef enum logic {
        SEARCH,
        TRACK
    } state_t;

    localparam logic [CW-1:0] LAST_PHASE = CW'(RATIO - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  phase_q, phase_d;
    logic [CW-1:0]  cur_phase;   // phase of the current sample within its symbol
    logic           take;        // current sample belongs to a tracked symbol
    logic           capture;     // current sample produces a strobe
    logic [WIDTH-1:0] cap_value;

    // State, phase counter and selected phase register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= SEARCH;
            cnt_q   <= '0;
            phase_q <= CW'(PHASE);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // Next-state logic: phase bookkeeping and capture decision for the current sample.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        cur_phase = '0;
        take      = 1'b0;
        if (sample_valid) begin
            if (sym_sync) begin
                // Sync wins in either state, even over the phase RATIO-1 sample.
                state_d   = TRACK;
                cnt_d     = CW'(1);
                phase_d   = phase_sel;
                cur_phase = '0;
                take      = 1'b1;
            end else if (state_q == TRACK) begin
                cur_phase = cnt_q;
                take      = 1'b1;
                cnt_d     = cnt_q + CW'(1);   // power-of-two RATIO wraps naturally
                if (cnt_q == LAST_PHASE) begin
                    // Reload only at the symbol boundary: one strobe per symbol.
                    phase_d = phase_sel;
                end
            end
        end
    end

`ifdef SAMPLES_DECIMATE_AVG_EN
    localparam int AW = WIDTH + CW;

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] sample_ext;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] acc_shift;

    assign sample_ext = AW'($signed(sample_in));
    assign acc_sum    = acc_q + sample_ext;
    assign acc_shift  = acc_sum >>> CW;       // floor division by RATIO
    assign cap_value  = acc_shift[WIDTH-1:0];
    assign capture    = take && (cur_phase == LAST_PHASE);

    // Integrator: phase 0 (including a sync sample) restarts the running sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (take) begin
            acc_q <= (cur_phase == '0) ? sample_ext : acc_sum;
        end
    end
`else
    assign cap_value = sample_in;
    // A sync sample compares against the freshly requested phase.
    assign capture   = take && (cur_phase == ((sample_valid && sym_sync) ? phase_sel : phase_q));
`endif

    // Output register and one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= capture;
            if (capture) begin
                data_out <= cap_value;
            end
        end
    end

    assign locked = (state_q == TRACK);

endmodule
